// File: rtl/sample_decimator.sv
// Buffers unsigned samples in a small FIFO and averages each 2^dec_sel-sample
// window into one output word with a single-cycle write strobe.
module sample_decimator #(
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic [1:0]         dec_sel,
    output logic               out_wr_en,
    output logic [D_WIDTH-1:0] out_data,
    output logic               drop
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ACC_W = D_WIDTH + 3;

    logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fill;
    logic               push;
    logic               pop;
    logic [D_WIDTH-1:0] head;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [2:0]         win_cnt;
    logic [2:0]         win_last;
    logic [1:0]         dec_lat;
    logic [1:0]         dec_eff;
    logic               win_done;

    assign in_ready = (fill != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = en && (fill != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // A fresh window takes dec_sel live so its first pop already uses the new length.
    always_comb begin
        dec_eff  = (win_cnt == '0) ? dec_sel : dec_lat;
        acc_next = ((win_cnt == '0) ? '0 : acc) + ACC_W'(head);
        case (dec_eff)
            2'd0:    win_last = 3'd0;
            2'd1:    win_last = 3'd1;
            2'd2:    win_last = 3'd3;
            default: win_last = 3'd7;
        endcase
        win_done = (win_cnt == win_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            win_cnt   <= '0;
            dec_lat   <= '0;
            out_wr_en <= 1'b0;
            out_data  <= '0;
            drop      <= 1'b0;
        end else begin
            out_wr_en <= 1'b0;
            if (in_valid && !in_ready) begin
                drop <= 1'b1;
            end
            if (pop) begin
                acc <= acc_next;
                if (win_cnt == '0) begin
                    dec_lat <= dec_sel;
                end
                if (win_done) begin
                    win_cnt   <= '0;
                    out_wr_en <= 1'b1;
                    out_data  <= D_WIDTH'(acc_next >> dec_eff);
                end else begin
                    win_cnt <= win_cnt + 3'd1;
                end
            end
        end
    end

endmodule
